// File: rtl/axi_sram_slave_if.sv
// AXI3-style bus bundle for axi_sram_slave.
//   AR/AW : read/write address channels (id, addr, len, size, burst, lock, cache, prot)
//   R     : read data (id, data, resp, last)
//   W     : write data (id, data, strb, last)
//   B     : write response (id, resp)
// modport slave  : the SRAM side (drives the readies and the R/B channels)
// modport master : the requester side (drives AR/AW/W and rready/bready)
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-outstanding-burst AXI slave in front of a MEM_WORDS x 32-bit SRAM.
// Ports:
//   aclk    - clock, all state changes on its rising edge
//   aresetn - asynchronous active-low reset (deassertion synchronised externally)
//   axi     - axi_sram_slave_if.slave bundle (AR, R, AW, W, B channels)
// Behaviour: one FSM (idle / read / write / write-response); reads win over writes when both
// address channels are valid in idle. FIXED, INCR and WRAP bursts; reserved burst type acts as
// INCR and sizes above 4 bytes act as 4 bytes. Upper address bits alias onto the array.
// Optional build macro AXI_SLV_RAND_STALL_EN: a 16-bit LFSR randomly throttles the readies and
// the presentation of new R beats and of bvalid, without ever retracting an asserted valid.
module axi_sram_slave #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input logic             aclk,
  input logic             aresetn,
  axi_sram_slave_if.slave axi
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StWresp} state_e;

  state_e            state_q, state_d;
  logic              rdy_en_q;
  logic [3:0]        id_q, id_d;
  logic [31:0]       addr_q, addr_d, addr_nxt;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;
  logic              bvalid_q, bvalid_d;
  logic [31:0]       rdata_q;
  logic              rd_load;
  logic [IdxW-1:0]   rd_idx;
  logic [31:0]       step, wrap_mask;
  logic              go, last_beat;
  logic              ar_hs, aw_hs, r_hs, w_hs, b_hs;

  logic [31:0]       mem [MEM_WORDS];

  // Stall gate: constant 1 in the default build, so timing is fully deterministic.
`ifdef AXI_SLV_RAND_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11, shifting right.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign go = lfsr_q[0];
`else
  assign go = 1'b1;
`endif

  // Outputs. Readies are held low until the first edge after reset release via rdy_en_q.
  assign axi.arready = (state_q == StIdle) & rdy_en_q & go;
  assign axi.awready = (state_q == StIdle) & rdy_en_q & go & ~axi.arvalid;
  assign axi.wready  = (state_q == StWr) & go;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rid     = id_q;
  assign axi.rresp   = 2'b00;
  assign axi.rlast   = rvalid_q & last_beat;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = id_q;
  assign axi.bresp   = (bvalid_q & err_q) ? 2'b10 : 2'b00;

  assign ar_hs     = axi.arvalid & axi.arready;
  assign aw_hs     = axi.awvalid & axi.awready;
  assign r_hs      = rvalid_q & axi.rready;
  assign w_hs      = axi.wvalid & axi.wready;
  assign b_hs      = bvalid_q & axi.bready;
  assign last_beat = (beat_q == len_q);

  // Sideband inputs with no effect on this slave.
  logic unused_inputs;
  assign unused_inputs = ^{axi.wid, axi.arlock, axi.arcache, axi.arprot,
                           axi.awlock, axi.awcache, axi.awprot};

  // Next beat address. The WRAP window is (len+1) beats of 1<<size bytes, aligned to its size.
  always_comb begin
    step      = 32'd1 << size_q;
    wrap_mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_nxt = addr_q + step;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    err_d    = err_q;
    rvalid_d = rvalid_q;
    bvalid_d = bvalid_q;
    rd_load  = 1'b0;
    rd_idx   = addr_nxt[IdxW+1:2];

    case (state_q)
      StIdle: begin
        if (ar_hs) begin
          id_d     = axi.arid;
          addr_d   = axi.araddr;
          len_d    = axi.arlen;
          size_d   = (axi.arsize > 3'd2) ? 2'd2 : axi.arsize[1:0];
          burst_d  = axi.arburst;
          beat_d   = 8'd0;
          rd_load  = 1'b1;
          rd_idx   = axi.araddr[IdxW+1:2];
          rvalid_d = go;
          state_d  = StRd;
        end else if (aw_hs) begin
          id_d    = axi.awid;
          addr_d  = axi.awaddr;
          len_d   = axi.awlen;
          size_d  = (axi.awsize > 3'd2) ? 2'd2 : axi.awsize[1:0];
          burst_d = axi.awburst;
          beat_d  = 8'd0;
          err_d   = 1'b0;
          state_d = StWr;
        end
      end

      StRd: begin
        if (r_hs) begin
          if (last_beat) begin
            rvalid_d = 1'b0;
            state_d  = StIdle;
          end else begin
            // Prefetch the next beat now so rdata is ready when rvalid rises.
            beat_d   = beat_q + 8'd1;
            addr_d   = addr_nxt;
            rd_load  = 1'b1;
            rvalid_d = go;
          end
        end else if (!rvalid_q) begin
          rvalid_d = go;
        end
      end

      StWr: begin
        if (w_hs) begin
          // Burst length is authoritative; wlast only feeds the error flag.
          if (axi.wlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            bvalid_d = go;
            state_d  = StWresp;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_nxt;
          end
        end
      end

      StWresp: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          err_d    = 1'b0;
          state_d  = StIdle;
        end else if (!bvalid_q) begin
          bvalid_d = go;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      rdy_en_q <= 1'b0;
      id_q     <= 4'd0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      size_q   <= 2'd0;
      burst_q  <= 2'd0;
      beat_q   <= 8'd0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
      if (rd_load) begin
        rdata_q <= mem[rd_idx];
      end
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) begin
          mem[addr_q[IdxW+1:2]][8*b +: 8] <= axi.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
